// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/forwarding control for the five-stage core,
// with a memory-wait timeout FSM and a saturating stall-cycle counter.
module hazard_ctrl #(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       id_rn,
   input  logic [3:0]       id_rm,
   input  logic [3:0]       id_rd,
   input  logic             id_use_rn,
   input  logic             id_use_rm,
   input  logic             id_use_rd,
   input  logic [3:0]       ex_rd,
   input  logic             ex_rf_en,
   input  logic             ex_load,
   input  logic [3:0]       mem_rd,
   input  logic             mem_rf_en,
   input  logic             mem_datamem_en,
   input  logic             mem_ready,
   input  logic [3:0]       wb_rd,
   input  logic             wb_rf_en,
   input  logic             branch_taken,
   output logic             nop_sel,
   output logic             pc_le,
   output logic             ifid_le,
   output logic             idex_le,
   output logic             exmem_le,
   output logic             memwb_le,
   output logic             ifid_clr,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [1:0]       fwd_c,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

   typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERROR} state_t;

   state_t        state;
   logic [WW-1:0] wait_cnt;
   logic          freeze;
   logic          load_use;
   logic          pc_stall;

   // EX results from a load are not available yet, so that stage is skipped.
   function automatic logic [1:0] fwd_sel(input logic [3:0] src, input logic used);
      logic [1:0] sel;
      sel = 2'b00;
      if (used && src != 4'd15) begin
         if (ex_rf_en && !ex_load && ex_rd == src)
            sel = 2'b01;
         else if (mem_rf_en && mem_rd == src)
            sel = 2'b10;
         else if (wb_rf_en && wb_rd == src)
            sel = 2'b11;
      end
      return sel;
   endfunction

   always_comb begin
      freeze   = (mem_datamem_en && !mem_ready) || state == S_ERROR;
      load_use = ex_load && ex_rf_en &&
                 ((id_use_rn && id_rn == ex_rd) ||
                  (id_use_rm && id_rm == ex_rd) ||
                  (id_use_rd && id_rd == ex_rd));
      pc_stall = freeze || (load_use && !branch_taken);
   end

   // Priority: reset forcing, then freeze, then branch flush, then load-use bubble.
   always_comb begin
      nop_sel  = 1'b0;
      ifid_clr = 1'b0;
      pc_le    = 1'b1;
      ifid_le  = 1'b1;
      idex_le  = 1'b1;
      exmem_le = 1'b1;
      memwb_le = 1'b1;
      fwd_a    = 2'b00;
      fwd_b    = 2'b00;
      fwd_c    = 2'b00;
      if (reset) begin
         nop_sel  = 1'b1;
         ifid_clr = 1'b1;
         pc_le    = 1'b0;
         ifid_le  = 1'b0;
         idex_le  = 1'b0;
         exmem_le = 1'b0;
         memwb_le = 1'b0;
      end else begin
         fwd_a = fwd_sel(id_rn, id_use_rn);
         fwd_b = fwd_sel(id_rm, id_use_rm);
         fwd_c = fwd_sel(id_rd, id_use_rd);
         if (freeze) begin
            pc_le    = 1'b0;
            ifid_le  = 1'b0;
            idex_le  = 1'b0;
            exmem_le = 1'b0;
            memwb_le = 1'b0;
         end else if (branch_taken) begin
            nop_sel  = 1'b1;
            ifid_clr = 1'b1;
         end else if (load_use) begin
            nop_sel = 1'b1;
            pc_le   = 1'b0;
            ifid_le = 1'b0;
         end
      end
   end

   // Wait-state FSM; the wait counter holds the number of cycles already spent in WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
         stall_count <= '0;
      end else begin
         if (pc_stall && stall_count != {CNT_W{1'b1}})
            stall_count <= stall_count + CNT_W'(1);
         case (state)
            S_RUN: begin
               if (freeze)
                  state <= S_WAIT;
            end
            S_WAIT: begin
               if (mem_ready) begin
                  state    <= S_RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_LAST) begin
                  state       <= S_ERROR;
                  mem_timeout <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            default: begin
               state <= S_ERROR;
            end
         endcase
      end
   end

endmodule
